// File: rtl/matrix_scan_driver.sv
// Row-multiplexed scan driver for the 8x8 bicolour LED matrix; blanking gap before each row drive.
// Optional per-frame column dimming is compiled in with `define MATRIX_DIM_EN (adds input dim).
module matrix_scan_driver #(
  parameter int DWELL      = 10_000,
  parameter int BLANK      = 16,
  parameter int ROW_ACT_LO = 1,
  parameter int COL_ACT_LO = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [127:0] frame_in,
`ifdef MATRIX_DIM_EN
  input  logic [2:0]   dim,
`endif
  output logic [7:0]   row_sel,
  output logic [7:0]   col_r,
  output logic [7:0]   col_g,
  output logic [2:0]   row_idx,
  output logic         frame_start
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW_RAW  = $clog2(CNT_MAX + 1);
  localparam int CW      = (CW_RAW < 1) ? 1 : CW_RAW;

  // BLANK=0 still spends one cycle in BLANK
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK == 0) ? 0 : BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'((DWELL == 0) ? 0 : DWELL - 1);

  localparam logic [7:0] ROW_OFF = (ROW_ACT_LO != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0] COL_OFF = (COL_ACT_LO != 0) ? 8'hFF : 8'h00;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    row_nxt;
  logic [127:0]  shadow;
  logic          latch;
  logic          drive, lit;
  logic [15:0]   row_bits;
  logic [7:0]    r_bits, g_bits, row_onehot;

`ifdef MATRIX_DIM_EN
  logic [2:0] dim_lat;
  int         thr;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    row_nxt   = row_idx;
    if (!en) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      row_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_BLANK;
          cnt_nxt   = '0;
          row_nxt   = '0;
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = S_DRIVE;
            cnt_nxt   = '0;
          end
        end
        S_DRIVE: begin
          if (cnt == DWELL_LAST) begin
            state_nxt = S_BLANK;
            cnt_nxt   = '0;
            row_nxt   = row_idx + 3'd1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          row_nxt   = '0;
        end
      endcase
    end
  end

  assign latch = (state_nxt == S_BLANK) && (state != S_BLANK) && (row_nxt == 3'd0);

  // Outputs are registered from next-state values so they line up with the state they describe
  always_comb begin
    drive    = (state_nxt == S_DRIVE);
    row_bits = shadow[{row_nxt, 4'b0000} +: 16];
    r_bits   = '0;
    g_bits   = '0;
    for (int unsigned c = 0; c < 8; c++) begin
      r_bits[c] = row_bits[2*c];
      g_bits[c] = row_bits[2*c+1];
    end
    row_onehot = 8'h01 << row_nxt;
`ifdef MATRIX_DIM_EN
    thr = ((int'(dim_lat) + 1) * DWELL) / 8;
    lit = drive && (int'(cnt_nxt) < thr);
`else
    lit = drive;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      row_idx     <= '0;
      shadow      <= '0;
      frame_start <= 1'b0;
      row_sel     <= ROW_OFF;
      col_r       <= COL_OFF;
      col_g       <= COL_OFF;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      row_idx     <= row_nxt;
      frame_start <= latch;
      if (latch) shadow <= frame_in;
      row_sel     <= drive ? (row_onehot ^ ROW_OFF) : ROW_OFF;
      col_r       <= lit ? (r_bits ^ COL_OFF) : COL_OFF;
      col_g       <= lit ? (g_bits ^ COL_OFF) : COL_OFF;
    end
  end

`ifdef MATRIX_DIM_EN
  always_ff @(posedge clk) begin
    if (rst)        dim_lat <= 3'd7;
    else if (latch) dim_lat <= dim;
  end
`endif

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver with DWELL=8, BLANK=2, active-low rows, active-high columns.
module tb_matrix_scan_driver;

  logic         clk = 1'b0;
  logic         rst, en;
  logic [127:0] frame_in;
  logic [7:0]   row_sel, col_r, col_g;
  logic [2:0]   row_idx;
  logic         frame_start;
`ifdef MATRIX_DIM_EN
  logic [2:0]   dim = 3'd7;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int sample_no = 0;
  int last_fs = -1000;

  localparam logic [127:0] F_PIX  = 128'h1;
  localparam logic [127:0] F_ROW7 = 128'hFFFF << 112;
  localparam logic [127:0] F_G23  = 128'h80 << 32;

  always #5 clk = ~clk;

  matrix_scan_driver #(
    .DWELL(8),
    .BLANK(2),
    .ROW_ACT_LO(1),
    .COL_ACT_LO(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .frame_in(frame_in),
`ifdef MATRIX_DIM_EN
    .dim(dim),
`endif
    .row_sel(row_sel),
    .col_r(col_r),
    .col_g(col_g),
    .row_idx(row_idx),
    .frame_start(frame_start)
  );

  task automatic tick();
    @(negedge clk);
    sample_no++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; frame_in = '0;
    repeat (3) tick();
    n_cmp++; if (row_sel !== 8'hFF) begin n_bad++; $display("FAIL reset row_sel got %h want ff", row_sel); end
    n_cmp++; if (col_r !== 8'h00) begin n_bad++; $display("FAIL reset col_r got %h want 00", col_r); end
    n_cmp++; if (col_g !== 8'h00) begin n_bad++; $display("FAIL reset col_g got %h want 00", col_g); end
    n_cmp++; if (row_idx !== 3'd0) begin n_bad++; $display("FAIL reset row_idx got %0d want 0", row_idx); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset frame_start got %b want 0", frame_start); end
  endtask

  // Frame 1: single red pixel at row 0 col 0; frame_in switched to row-7 pattern mid row 3
  task automatic test_single_pixel();
    int r, p;
    logic [7:0] oh, e_row, e_r;
    rst = 1'b0; en = 1'b1; frame_in = F_PIX;
    for (int j = 1; j <= 80; j++) begin
      tick();
      r = (j - 1) / 10; p = (j - 1) % 10;
      oh = 8'h01 << r;
      e_row = (p < 2) ? 8'hFF : ~oh;
      e_r = (p >= 2 && r == 0) ? 8'h01 : 8'h00;
      if (frame_start === 1'b1) last_fs = sample_no;
      n_cmp++; if (frame_start !== (j == 1)) begin n_bad++; $display("FAIL pix frame_start j=%0d got %b want %b", j, frame_start, (j == 1)); end
      n_cmp++; if (row_sel !== e_row) begin n_bad++; $display("FAIL pix row_sel j=%0d got %h want %h", j, row_sel, e_row); end
      n_cmp++; if (col_r !== e_r) begin n_bad++; $display("FAIL pix col_r j=%0d got %h want %h", j, col_r, e_r); end
      n_cmp++; if (col_g !== 8'h00) begin n_bad++; $display("FAIL pix col_g j=%0d got %h want 00", j, col_g); end
      n_cmp++; if (row_idx !== 3'(r)) begin n_bad++; $display("FAIL pix row_idx j=%0d got %0d want %0d", j, row_idx, r); end
      if (j == 35) frame_in = F_ROW7;
    end
  endtask

  // Frame 2: row 7 full R+G; frame_in changed again mid row 3 must not reach rows 3-7
  task automatic test_row7();
    int r, p;
    logic [7:0] oh, e_row, e_c;
    for (int j = 1; j <= 80; j++) begin
      tick();
      r = (j - 1) / 10; p = (j - 1) % 10;
      oh = 8'h01 << r;
      e_row = (p < 2) ? 8'hFF : ~oh;
      e_c = (p >= 2 && r == 7) ? 8'hFF : 8'h00;
      if (frame_start === 1'b1) begin
        n_cmp++; if (sample_no - last_fs !== 80) begin n_bad++; $display("FAIL row7 frame_period got %0d want 80", sample_no - last_fs); end
        last_fs = sample_no;
      end
      n_cmp++; if (frame_start !== (j == 1)) begin n_bad++; $display("FAIL row7 frame_start j=%0d got %b want %b", j, frame_start, (j == 1)); end
      n_cmp++; if (row_sel !== e_row) begin n_bad++; $display("FAIL row7 row_sel j=%0d got %h want %h", j, row_sel, e_row); end
      n_cmp++; if (col_r !== e_c) begin n_bad++; $display("FAIL row7 col_r j=%0d got %h want %h", j, col_r, e_c); end
      n_cmp++; if (col_g !== e_c) begin n_bad++; $display("FAIL row7 col_g j=%0d got %h want %h", j, col_g, e_c); end
      if (j == 35) frame_in = F_G23;
    end
  endtask

  // Frame 3: new pattern (row 2 green col 3) appears; en dropped during row 5 drive
  task automatic test_no_tear();
    int r, p;
    logic [7:0] oh, e_row, e_g;
    for (int j = 1; j <= 55; j++) begin
      tick();
      r = (j - 1) / 10; p = (j - 1) % 10;
      oh = 8'h01 << r;
      e_row = (p < 2) ? 8'hFF : ~oh;
      e_g = (p >= 2 && r == 2) ? 8'h08 : 8'h00;
      n_cmp++; if (frame_start !== (j == 1)) begin n_bad++; $display("FAIL tear frame_start j=%0d got %b want %b", j, frame_start, (j == 1)); end
      n_cmp++; if (row_sel !== e_row) begin n_bad++; $display("FAIL tear row_sel j=%0d got %h want %h", j, row_sel, e_row); end
      n_cmp++; if (col_r !== 8'h00) begin n_bad++; $display("FAIL tear col_r j=%0d got %h want 00", j, col_r); end
      n_cmp++; if (col_g !== e_g) begin n_bad++; $display("FAIL tear col_g j=%0d got %h want %h", j, col_g, e_g); end
    end
    n_cmp++; if (row_sel !== 8'hDF) begin n_bad++; $display("FAIL tear row5_before_drop got %h want df", row_sel); end
    en = 1'b0;
  endtask

  task automatic test_en_drop();
    logic [7:0] e_row, e_r;
    for (int j = 1; j <= 3; j++) begin
      tick();
      n_cmp++; if (row_sel !== 8'hFF) begin n_bad++; $display("FAIL drop row_sel j=%0d got %h want ff", j, row_sel); end
      n_cmp++; if ((col_r | col_g) !== 8'h00) begin n_bad++; $display("FAIL drop cols j=%0d got %h/%h want 00/00", j, col_r, col_g); end
      n_cmp++; if (row_idx !== 3'd0) begin n_bad++; $display("FAIL drop row_idx j=%0d got %0d want 0", j, row_idx); end
      n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL drop frame_start j=%0d got %b want 0", j, frame_start); end
    end
    en = 1'b1; frame_in = F_PIX;
    for (int j = 1; j <= 12; j++) begin
      tick();
      e_row = (j >= 3 && j <= 10) ? 8'hFE : 8'hFF;
      e_r = (j >= 3 && j <= 10) ? 8'h01 : 8'h00;
      n_cmp++; if (frame_start !== (j == 1)) begin n_bad++; $display("FAIL restart frame_start j=%0d got %b want %b", j, frame_start, (j == 1)); end
      n_cmp++; if (row_sel !== e_row) begin n_bad++; $display("FAIL restart row_sel j=%0d got %h want %h", j, row_sel, e_row); end
      n_cmp++; if (col_r !== e_r) begin n_bad++; $display("FAIL restart col_r j=%0d got %h want %h", j, col_r, e_r); end
      n_cmp++; if (row_idx !== ((j <= 10) ? 3'd0 : 3'd1)) begin n_bad++; $display("FAIL restart row_idx j=%0d got %0d", j, row_idx); end
    end
  endtask

  // Reset asserted mid-drive with en still high
  task automatic test_reset_mid();
    repeat (3) tick();
    n_cmp++; if (row_sel !== 8'hFD) begin n_bad++; $display("FAIL rmid row1_drive got %h want fd", row_sel); end
    rst = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      tick();
      n_cmp++; if (row_sel !== 8'hFF) begin n_bad++; $display("FAIL rmid row_sel j=%0d got %h want ff", j, row_sel); end
      n_cmp++; if (row_idx !== 3'd0) begin n_bad++; $display("FAIL rmid row_idx j=%0d got %0d want 0", j, row_idx); end
      n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rmid frame_start j=%0d got %b want 0", j, frame_start); end
    end
    rst = 1'b0;
    tick();
    n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL rmid relatch got %b want 1", frame_start); end
    repeat (2) tick();
    n_cmp++; if (row_sel !== 8'hFE || col_r !== 8'h01) begin n_bad++; $display("FAIL rmid first_drive got %h/%h want fe/01", row_sel, col_r); end
  endtask

`ifdef MATRIX_DIM_EN
  task automatic test_dim();
    logic [7:0] e_r;
    en = 1'b0; tick();
    dim = 3'd1; en = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      e_r = (j == 3 || j == 4) ? 8'h01 : 8'h00;
      n_cmp++; if (col_r !== e_r) begin n_bad++; $display("FAIL dim1 col_r j=%0d got %h want %h", j, col_r, e_r); end
      if (j >= 3) begin
        n_cmp++; if (row_sel !== 8'hFE) begin n_bad++; $display("FAIL dim1 row_sel j=%0d got %h want fe", j, row_sel); end
      end
    end
    en = 1'b0; tick();
    dim = 3'd7; en = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      e_r = (j >= 3) ? 8'h01 : 8'h00;
      n_cmp++; if (col_r !== e_r) begin n_bad++; $display("FAIL dim7 col_r j=%0d got %h want %h", j, col_r, e_r); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_pixel();
    test_row7();
    test_no_tear();
    test_en_drop();
    test_reset_mid();
`ifdef MATRIX_DIM_EN
    test_dim();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
